// File: rtl/emmc_req_arbiter_if.sv
// Request/grant bus between block-level requesters, the arbiter and the emmc_sm transaction port.
`default_nettype none

interface emmc_req_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int BLK_IDX_W = 16,
  parameter int BLK_CNT_W = 2
);
  logic [N_REQ-1:0]           req_i;
  logic [N_REQ-1:0]           req_we_i;
  logic [N_REQ*BLK_IDX_W-1:0] req_blk_idx_i;
  logic [N_REQ*BLK_CNT_W-1:0] req_blk_cnt_i;
  logic [N_REQ*8-1:0]         req_wr_dat_i;
  logic [N_REQ-1:0]           gnt_o;
  logic [N_REQ-1:0]           req_dvalid_o;
  logic [7:0]                 req_rd_dat_o;
  logic [N_REQ-1:0]           done_o;
  logic                       err_o;
  logic                       emmc_ready_i;
  logic                       emmc_dvalid_i;
  logic [7:0]                 emmc_rd_dat_i;
  logic                       emmc_start_o;
  logic                       emmc_we_o;
  logic [BLK_IDX_W-1:0]       emmc_blk_idx_o;
  logic [BLK_CNT_W-1:0]       emmc_blk_cnt_o;
  logic [7:0]                 emmc_wr_dat_o;

  modport master (
    output req_i, req_we_i, req_blk_idx_i, req_blk_cnt_i, req_wr_dat_i,
    output emmc_ready_i, emmc_dvalid_i, emmc_rd_dat_i,
    input  gnt_o, req_dvalid_o, req_rd_dat_o, done_o, err_o,
    input  emmc_start_o, emmc_we_o, emmc_blk_idx_o, emmc_blk_cnt_o, emmc_wr_dat_o
  );

  modport slave (
    input  req_i, req_we_i, req_blk_idx_i, req_blk_cnt_i, req_wr_dat_i,
    input  emmc_ready_i, emmc_dvalid_i, emmc_rd_dat_i,
    output gnt_o, req_dvalid_o, req_rd_dat_o, done_o, err_o,
    output emmc_start_o, emmc_we_o, emmc_blk_idx_o, emmc_blk_cnt_o, emmc_wr_dat_o
  );
endinterface

`default_nettype wire

// File: rtl/emmc_req_arbiter.sv
// Round-robin arbiter sharing one emmc_sm transaction port between N_REQ block requesters,
// with byte-count and acknowledge-timeout checking per transaction.
`default_nettype none

module emmc_req_arbiter #(
  parameter int N_REQ     = 2,
  parameter int BLK_IDX_W = 16,
  parameter int BLK_CNT_W = 2,
  parameter int ACK_TO    = 1024
) (
  input  logic              clk_core,
  input  logic              rst_tk,
  emmc_req_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W  = BLK_CNT_W + 9;
  localparam int TO_W  = $clog2(ACK_TO + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    XFER     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [BC_W-1:0]   byte_cnt;
  logic [BC_W-1:0]   byte_cnt_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              in_xfer;
  logic              cnt_bad;
  logic [BLK_CNT_W-1:0] pick_cnt;
  logic [7:0]        wr_mux;

  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % N_REQ);
  endfunction

  // Walk from the highest offset down so the requester closest to rr_ptr is the last writer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[wrap(int'(rr_ptr) + i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap(int'(rr_ptr) + i);
      end
    end
  end

  assign pick_cnt = bus.req_blk_cnt_i[pick_idx*BLK_CNT_W +: BLK_CNT_W];

  // Strobes are honoured from WAIT_ACK onward: emmc_sm may strobe before ready visibly drops.
  assign in_xfer      = (state == WAIT_ACK) || (state == XFER);
  assign byte_cnt_nxt = (in_xfer && bus.emmc_dvalid_i && !(&byte_cnt)) ? byte_cnt + 1'b1 : byte_cnt;
  assign cnt_bad      = (byte_cnt_nxt != {bus.emmc_blk_cnt_o, 9'd0});

  assign bus.req_dvalid_o = (in_xfer && bus.emmc_dvalid_i) ? bus.gnt_o : '0;
  assign bus.req_rd_dat_o = in_xfer ? bus.emmc_rd_dat_i : 8'd0;

  always_comb begin
    wr_mux = 8'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (bus.gnt_o[k]) wr_mux = wr_mux | bus.req_wr_dat_i[k*8 +: 8];
    end
  end
  assign bus.emmc_wr_dat_o = wr_mux;

  always_ff @(posedge clk_core or posedge rst_tk) begin
    if (rst_tk) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      gnt_idx            <= '0;
      byte_cnt           <= '0;
      to_cnt             <= '0;
      bus.gnt_o          <= '0;
      bus.done_o         <= '0;
      bus.err_o          <= 1'b0;
      bus.emmc_start_o   <= 1'b0;
      bus.emmc_we_o      <= 1'b0;
      bus.emmc_blk_idx_o <= '0;
      bus.emmc_blk_cnt_o <= '0;
    end else begin
      bus.emmc_start_o <= 1'b0;
      bus.done_o       <= '0;
      bus.err_o        <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          if (bus.emmc_ready_i && pick_vld) begin
            bus.gnt_o          <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_idx            <= pick_idx;
            bus.emmc_we_o      <= bus.req_we_i[pick_idx];
            bus.emmc_blk_idx_o <= bus.req_blk_idx_i[pick_idx*BLK_IDX_W +: BLK_IDX_W];
            bus.emmc_blk_cnt_o <= pick_cnt;
            if (pick_cnt == '0) begin
              bus.done_o <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
              bus.err_o  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.emmc_start_o <= 1'b1;
          state            <= WAIT_ACK;
        end
        WAIT_ACK: begin
          byte_cnt <= byte_cnt_nxt;
          to_cnt   <= to_cnt + 1'b1;
          if (!bus.emmc_ready_i) begin
            state <= XFER;
          end else if (to_cnt == TO_W'(ACK_TO - 1)) begin
            bus.done_o <= bus.gnt_o;
            bus.err_o  <= 1'b1;
            state      <= DONE;
          end
        end
        XFER: begin
          byte_cnt <= byte_cnt_nxt;
          if (bus.emmc_ready_i) begin
            bus.done_o <= bus.gnt_o;
            bus.err_o  <= cnt_bad;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.gnt_o <= '0;
          rr_ptr    <= wrap(int'(gnt_idx) + 1);
          byte_cnt  <= '0;
          to_cnt    <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_emmc_req_arbiter.sv
// Directed bench for emmc_req_arbiter: emmc_sm behavioural model plus a done/err scoreboard.
`default_nettype none

module tb_emmc_req_arbiter;

  localparam int N_REQ     = 2;
  localparam int BLK_IDX_W = 16;
  localparam int BLK_CNT_W = 2;
  localparam int ACK_TO    = 1024;

  logic clk_core = 1'b0;
  logic rst_tk   = 1'b1;
  always #5 clk_core = ~clk_core;

  emmc_req_arbiter_if #(.N_REQ(N_REQ), .BLK_IDX_W(BLK_IDX_W), .BLK_CNT_W(BLK_CNT_W)) bus ();

  emmc_req_arbiter #(
    .N_REQ(N_REQ), .BLK_IDX_W(BLK_IDX_W), .BLK_CNT_W(BLK_CNT_W), .ACK_TO(ACK_TO)
  ) dut (
    .clk_core(clk_core),
    .rst_tk  (rst_tk),
    .bus     (bus)
  );

  typedef struct packed {
    logic [N_REQ-1:0] done;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   dv_cnt[N_REQ];
  int   start_pulses = 0;
  int   done_pulses  = 0;
  int   onehot_viol  = 0;

  always @(negedge clk_core) begin
    if (!rst_tk) begin
      for (int k = 0; k < N_REQ; k++) if (bus.req_dvalid_o[k]) dv_cnt[k]++;
      if (bus.emmc_start_o) start_pulses++;
      if (bus.done_o != '0) done_pulses++;
      if ($countones(bus.gnt_o) > 1) onehot_viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 32'({bus.gnt_o, bus.req_dvalid_o, bus.done_o, bus.err_o,
                              bus.emmc_start_o, bus.emmc_we_o, bus.emmc_blk_cnt_o}), 32'd0);
    check({tag, " data"}, {bus.req_rd_dat_o, bus.emmc_blk_idx_o, bus.emmc_wr_dat_o}, 32'd0);
  endtask

  task automatic set_req(input int k, input logic we, input logic [15:0] idx,
                         input logic [1:0] cnt, input logic [7:0] wd);
    bus.req_we_i[k]             = we;
    bus.req_blk_idx_i[k*16 +: 16] = idx;
    bus.req_blk_cnt_i[k*2 +: 2]   = cnt;
    bus.req_wr_dat_i[k*8 +: 8]    = wd;
    bus.req_i[k]                = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (bus.emmc_start_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, " start"}, 32'(bus.emmc_start_o), 32'd1);
  endtask

  // emmc_sm model: acknowledge the start, strobe nbytes, then return to ready.
  task automatic run_xfer(input string tag, input int nbytes, input logic [7:0] exp_wd,
                          input logic [N_REQ-1:0] exp_gnt);
    bus.emmc_ready_i = 1'b0;
    step();
    for (int i = 0; i < nbytes; i++) begin
      bus.emmc_dvalid_i = 1'b1;
      bus.emmc_rd_dat_i = 8'(i * 7 + 3);
      if (i == 5) begin
        #1;
        check({tag, " rd_dat"}, 32'(bus.req_rd_dat_o), 32'(8'(i * 7 + 3)));
        check({tag, " wr_dat"}, 32'(bus.emmc_wr_dat_o), 32'(exp_wd));
        check({tag, " dvalid"}, 32'(bus.req_dvalid_o), 32'(exp_gnt));
      end
      step();
    end
    bus.emmc_dvalid_i = 1'b0;
    bus.emmc_ready_i  = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit drop, output int n);
    exp_t e;
    n = 0;
    while (bus.done_o == '0 && n < budget) begin
      step();
      n++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'('0);
    check({tag, " done"}, 32'(bus.done_o), 32'(e.done));
    check({tag, " err"}, 32'(bus.err_o), 32'(e.err));
    if (drop) bus.req_i = bus.req_i & ~bus.done_o;
  endtask

  initial begin
    int n;
    int sp;
    int dp;
    foreach (dv_cnt[k]) dv_cnt[k] = 0;
    bus.req_i = '0; bus.req_we_i = '0; bus.req_blk_idx_i = '0;
    bus.req_blk_cnt_i = '0; bus.req_wr_dat_i = '0;
    bus.emmc_ready_i = 1'b1; bus.emmc_dvalid_i = 1'b0; bus.emmc_rd_dat_i = 8'h00;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst_tk = 1'b0;
    step();

    // Single requester, write 2 blocks
    set_req(0, 1'b1, 16'h0010, 2'd2, 8'hA5);
    sb.push_back('{2'b01, 1'b0});
    step();
    check("t1 start early", 32'(bus.emmc_start_o), 32'd0);
    check("t1 gnt", 32'(bus.gnt_o), 32'd1);
    step();
    check("t1 start at 2", 32'(bus.emmc_start_o), 32'd1);
    check("t1 blk_idx", 32'(bus.emmc_blk_idx_o), 32'h10);
    check("t1 we", 32'(bus.emmc_we_o), 32'd1);
    check("t1 blk_cnt", 32'(bus.emmc_blk_cnt_o), 32'd2);
    dv_cnt[0] = 0;
    run_xfer("t1", 1024, 8'hA5, 2'b01);
    wait_done("t1", 20, 1'b1, n);
    check("t1 strobes", 32'(dv_cnt[0]), 32'd1024);
    step();
    check("t1 done width", 32'(bus.done_o), 32'd0);

    // Contention from reset: both requesters held high
    rst_tk = 1'b1;
    step();
    rst_tk = 1'b0;
    sb.delete();
    onehot_viol = 0;
    set_req(0, 1'b0, 16'h0100, 2'd1, 8'h11);
    set_req(1, 1'b1, 16'h0200, 2'd1, 8'h22);
    for (int t = 0; t < 4; t++) begin
      logic [N_REQ-1:0] g;
      g = (t % 2 == 0) ? 2'b01 : 2'b10;
      sb.push_back('{g, 1'b0});
      wait_start("t2");
      check("t2 gnt order", 32'(bus.gnt_o), 32'(g));
      check("t2 blk_idx", 32'(bus.emmc_blk_idx_o), (t % 2 == 0) ? 32'h100 : 32'h200);
      run_xfer("t2", 512, (t % 2 == 0) ? 8'h11 : 8'h22, g);
      wait_done("t2", 20, 1'b0, n);
    end
    bus.req_i = '0;
    check("t2 gnt onehot", 32'(onehot_viol), 32'd0);

    // Short transfer
    step();
    set_req(0, 1'b1, 16'h0020, 2'd1, 8'h5A);
    sb.push_back('{2'b01, 1'b1});
    wait_start("t3");
    run_xfer("t3", 500, 8'h5A, 2'b01);
    wait_done("t3", 20, 1'b1, n);

    // Acknowledge timeout, then a normal request from the other side
    step();
    set_req(0, 1'b0, 16'h0030, 2'd1, 8'h00);
    sb.push_back('{2'b01, 1'b1});
    wait_start("t4");
    wait_done("t4", 1100, 1'b1, n);
    check("t4 timeout cycles", 32'(n), 32'(ACK_TO));
    set_req(1, 1'b0, 16'h0040, 2'd1, 8'h77);
    sb.push_back('{2'b10, 1'b0});
    wait_start("t4b");
    run_xfer("t4b", 512, 8'h77, 2'b10);
    wait_done("t4b", 20, 1'b1, n);

    // Zero count
    step();
    sp = start_pulses;
    set_req(1, 1'b1, 16'h0050, 2'd0, 8'h00);
    sb.push_back('{2'b10, 1'b1});
    wait_done("t5", 10, 1'b1, n);
    check("t5 latency", 32'(n <= 3), 32'd1);
    step();
    step();
    check("t5 no start", 32'(start_pulses), 32'(sp));

    // Reset mid-transfer, then a fresh request
    set_req(0, 1'b1, 16'h0060, 2'd2, 8'hC3);
    wait_start("t6");
    dp = done_pulses;
    bus.emmc_ready_i = 1'b0;
    step();
    for (int i = 0; i < 100; i++) begin
      bus.emmc_dvalid_i = 1'b1;
      step();
    end
    rst_tk = 1'b1;
    #1;
    check_all_zero("t6 async rst");
    bus.emmc_dvalid_i = 1'b0;
    bus.emmc_ready_i  = 1'b1;
    bus.req_i         = '0;
    step();
    step();
    check("t6 no done", 32'(done_pulses), 32'(dp));
    rst_tk = 1'b0;
    step();
    set_req(0, 1'b1, 16'h0070, 2'd1, 8'h3C);
    sb.push_back('{2'b01, 1'b0});
    wait_start("t6b");
    check("t6b blk_idx", 32'(bus.emmc_blk_idx_o), 32'h70);
    run_xfer("t6b", 512, 8'h3C, 2'b01);
    wait_done("t6b", 20, 1'b1, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
